// File: rtl/demux4_pkg.sv
// Shared constants for the demux4 dispatcher: channel count, mode encodings and FSM states.
// Used by demux4_dispatch and rr_pick4.
package demux4_pkg;

   localparam int NCH = 4;

   localparam logic MODE_RR  = 1'b0;
   localparam logic MODE_DIR = 1'b1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   function automatic logic [NCH-1:0] chan_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/demux4_dispatch_rr_pick4.sv
// Rotate-priority picker: first enabled channel after ptr, searching ptr+1, ptr+2, ... (mod 4).
// Purely combinational; found=0 when no channel is enabled.
module rr_pick4
   import demux4_pkg::*;
(
   input  logic [1:0]     ptr,
   input  logic [NCH-1:0] chan_en,
   output logic           found,
   output logic [1:0]     idx
);

   logic [1:0]     cand [NCH];
   logic [NCH-1:0] hit;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_cand
         assign cand[gi] = ptr + 2'(gi + 1);
         assign hit[gi]  = chan_en[cand[gi]];
      end
   endgenerate

   // Scan from the farthest candidate down so the nearest hit wins.
   always_comb begin
      found = |hit;
      idx   = cand[0];
      for (int k = NCH - 1; k >= 0; k--) begin
         if (hit[k]) idx = cand[k];
      end
   end

endmodule

// File: rtl/demux4_dispatch.sv
// Burst dispatcher feeding a 1-to-4 demux: grants the input stream to one channel for BURST beats.
// Define DEMUX4_DISPATCH_STATS_EN to add saturating per-channel delivered-beat counters (beat_cnt).
module demux4_dispatch
   import demux4_pkg::*;
#(
   parameter int DW    = 8,
   parameter int BURST = 4
`ifdef DEMUX4_DISPATCH_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic [1:0]        dest,
   input  logic [NCH-1:0]    chan_en,
   input  logic              in_valid,
   input  logic [DW-1:0]     in_data,
   output logic              in_ready,
   output logic [NCH-1:0]    out_valid,
   output logic [DW-1:0]     out_data,
   input  logic [NCH-1:0]    out_ready,
   output logic [1:0]        cur_chan,
   output logic              busy
`ifdef DEMUX4_DISPATCH_STATS_EN
   ,
   output logic [NCH*CNT_W-1:0] beat_cnt
`endif
);

   localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;

   logic [0:0]    state_reg, state_next;
   logic [1:0]    cur_chan_reg, cur_chan_next;
   logic [1:0]    ptr_reg, ptr_next;
   logic [BCW-1:0] bcnt_reg, bcnt_next;
   logic          full_reg, full_next;
   logic [1:0]    reg_chan_reg, reg_chan_next;
   logic [DW-1:0] data_reg, data_next;

   logic          rr_found;
   logic [1:0]    rr_idx;
   logic          accept;
   logic          drain;
   logic          last_beat;

   rr_pick4 u_pick (
      .ptr     (ptr_reg),
      .chan_en (chan_en),
      .found   (rr_found),
      .idx     (rr_idx)
   );

   // The output stage may drain and reload in the same cycle, giving 1 beat/clk.
   assign drain     = full_reg && out_ready[reg_chan_reg];
   assign in_ready  = (state_reg == ST_BURST) && chan_en[cur_chan_reg] && (!full_reg || out_ready[reg_chan_reg]);
   assign accept    = in_valid && in_ready;
   assign last_beat = (bcnt_reg == BCW'(BURST - 1));

   always_comb begin
      state_next    = state_reg;
      cur_chan_next = cur_chan_reg;
      ptr_next      = ptr_reg;
      bcnt_next     = bcnt_reg;
      case (state_reg)
         ST_IDLE: begin
            bcnt_next = '0;
            if (mode == MODE_DIR) begin
               if (chan_en[dest]) begin
                  state_next    = ST_BURST;
                  cur_chan_next = dest;
               end
            end else if (rr_found) begin
               state_next    = ST_BURST;
               cur_chan_next = rr_idx;
            end
         end
         ST_BURST: begin
            if (!chan_en[cur_chan_reg]) begin
               state_next = ST_IDLE;
               bcnt_next  = '0;
               ptr_next   = cur_chan_reg;
            end else if (accept) begin
               if (last_beat) begin
                  state_next = ST_IDLE;
                  bcnt_next  = '0;
                  ptr_next   = cur_chan_reg;
               end else begin
                  bcnt_next = bcnt_reg + BCW'(1);
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      full_next     = full_reg;
      reg_chan_next = reg_chan_reg;
      data_next     = data_reg;
      if (accept) begin
         full_next     = 1'b1;
         reg_chan_next = cur_chan_reg;
         data_next     = in_data;
      end else if (drain) begin
         full_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         cur_chan_reg <= 2'd0;
         ptr_reg      <= 2'd3;
         bcnt_reg     <= '0;
         full_reg     <= 1'b0;
         reg_chan_reg <= 2'd0;
         data_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         cur_chan_reg <= cur_chan_next;
         ptr_reg      <= ptr_next;
         bcnt_reg     <= bcnt_next;
         full_reg     <= full_next;
         reg_chan_reg <= reg_chan_next;
         data_reg     <= data_next;
      end
   end

   // chan_en deliberately does not gate out_valid: a held beat always drains.
   assign out_valid = full_reg ? chan_onehot(reg_chan_reg) : '0;
   assign out_data  = data_reg;
   assign cur_chan  = cur_chan_reg;
   assign busy      = (state_reg == ST_BURST);

`ifdef DEMUX4_DISPATCH_STATS_EN
   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_stats
         logic [CNT_W-1:0] cnt_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg <= '0;
            end else if (out_valid[gi] && out_ready[gi] && (cnt_reg != '1)) begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end
         assign beat_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
      end
   endgenerate
`endif

endmodule

// File: tb/tb_demux4_dispatch.sv
// Directed bench for demux4_dispatch with a scoreboard of expected (channel, data) beats.
// Define DEMUX4_DISPATCH_STATS_EN to also exercise the saturating beat counters.
module tb_demux4_dispatch;

   localparam int DW    = 8;
   localparam int BURST = 4;
`ifdef DEMUX4_DISPATCH_STATS_EN
   localparam int CNT_W = 4;
`endif

   typedef struct {
      logic [1:0]    ch;
      logic [DW-1:0] data;
   } sb_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          mode;
   logic [1:0]    dest;
   logic [3:0]    chan_en;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic [3:0]    out_valid;
   logic [DW-1:0] out_data;
   logic [3:0]    out_ready;
   logic [1:0]    cur_chan;
   logic          busy;
`ifdef DEMUX4_DISPATCH_STATS_EN
   logic [4*CNT_W-1:0] beat_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   int acc      = 0;
   int beats    = 0;
   int stalls   = 0;
   logic [1:0] grant_q [$];
   sb_t        sb_q [$];

   always #5 clk = ~clk;

   demux4_dispatch #(
      .DW    (DW),
      .BURST (BURST)
`ifdef DEMUX4_DISPATCH_STATS_EN
      ,
      .CNT_W (CNT_W)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .dest      (dest),
      .chan_en   (chan_en),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .cur_chan  (cur_chan),
      .busy      (busy)
`ifdef DEMUX4_DISPATCH_STATS_EN
      ,
      .beat_cnt  (beat_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample handshakes just after inputs settle, then advance one clock.
   task automatic tick();
      sb_t        e;
      logic       adv;
      logic [3:0] exp_oh;
      #1;
      adv = 1'b0;
      if (!rst) begin
         chk("onehot0", $onehot0(out_valid), 1);
         if (in_valid && !in_ready) stalls++;
         if (|(out_valid & out_ready)) begin
            chk("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
               e      = sb_q.pop_front();
               exp_oh = 4'b0001 << e.ch;
               chk("out_valid", out_valid, exp_oh);
               chk("out_data", out_data, e.data);
               $display("beat out ch=%0d data=%0h", e.ch, out_data);
               if (out_ready == 4'hF) chk("latency", sb_q.size(), 0);
            end
         end
         if (in_valid && in_ready) begin
            chk("grant_avail", grant_q.size() > 0, 1);
            if (grant_q.size() > 0) begin
               e.ch   = grant_q[0];
               e.data = in_data;
               sb_q.push_back(e);
               beats++;
               if (beats == BURST) begin
                  void'(grant_q.pop_front());
                  beats = 0;
               end
            end
            acc++;
            adv = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      if (adv) in_data = in_data + 8'd1;
   endtask

   task automatic run_until(input int target, input int budget);
      int n = 0;
      while (acc < target && n < budget) begin
         tick();
         n++;
      end
      chk("reach_target", acc, target);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
      tick();
      rst    = 1'b0;
      acc    = 0;
      beats  = 0;
      stalls = 0;
      sb_q.delete();
      grant_q.delete();
   endtask

   task automatic drain_check();
      in_valid = 1'b0;
      repeat (3) tick();
      chk("drain_empty", sb_q.size(), 0);
   endtask

   initial begin
      rst       = 1'b1;
      mode      = 1'b0;
      dest      = 2'd0;
      chan_en   = 4'hF;
      in_valid  = 1'b0;
      in_data   = 8'h10;
      out_ready = 4'hF;
      @(posedge clk);
      #1;

      // Reset state
      tick();
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cur_chan", cur_chan, 0);
      chk("rst_in_ready", in_ready, 0);
`ifdef DEMUX4_DISPATCH_STATS_EN
      chk("rst_beat_cnt", beat_cnt, 0);
`endif

      // Round-robin over all four channels at full rate
      do_reset();
      grant_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      in_valid = 1'b1;
      run_until(20, 200);
      chk("rr_idle_cycles", stalls, 5);
      drain_check();
      $display("test rr_all done");

      // Round-robin over channels 1 and 3 only
      chan_en = 4'b1010;
      do_reset();
      grant_q = '{2'd1, 2'd3, 2'd1};
      in_valid = 1'b1;
      run_until(12, 200);
      drain_check();
      $display("test rr_1010 done");

      // Directed to ch2 with a 3-cycle backpressure stall mid-burst
      chan_en = 4'hF;
      mode    = 1'b1;
      dest    = 2'd2;
      do_reset();
      grant_q = '{2'd2};
      in_valid = 1'b1;
      run_until(2, 50);
      out_ready = 4'b1011;
      dest      = 2'd1;
      repeat (3) begin
         #1;
         chk("stall_in_ready", in_ready, 0);
         chk("stall_out_valid", out_valid, 4'b0100);
         chk("stall_cur_chan", cur_chan, 2);
         tick();
      end
      out_ready = 4'hF;
      dest      = 2'd2;
      run_until(4, 50);
      drain_check();
      $display("test dir_stall done");

      // Channel disabled mid-burst: held beat still delivered, then next grant
      mode    = 1'b0;
      chan_en = 4'hF;
      do_reset();
      grant_q = '{2'd0};
      in_valid = 1'b1;
      run_until(2, 50);
      chan_en = 4'b1110;
      #1;
      chk("drop_in_ready", in_ready, 0);
      chk("drop_held_valid", out_valid, 4'b0001);
      tick();
      chk("drop_busy", busy, 0);
      chk("drop_out_valid", out_valid, 0);
      void'(grant_q.pop_front());
      beats = 0;
      grant_q.push_back(2'd1);
      run_until(6, 50);
      drain_check();
      $display("test chan_drop done");

      // Reset pulsed mid-burst (ch1) with the output register full
      chan_en = 4'hF;
      do_reset();
      grant_q = '{2'd0, 2'd1};
      in_valid = 1'b1;
      run_until(5, 50);
      out_ready = 4'h0;
      #1;
      chk("pre_rst_full", out_valid, 4'b0010);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      sb_q.delete();
      grant_q.delete();
      beats     = 0;
      grant_q.push_back(2'd0);
      out_ready = 4'hF;
      run_until(7, 50);
      drain_check();
      $display("test mid_reset done");

`ifdef DEMUX4_DISPATCH_STATS_EN
      // Saturating counters: 20 beats to ch0 with a 4-bit counter
      mode    = 1'b1;
      dest    = 2'd0;
      chan_en = 4'hF;
      do_reset();
      grant_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
      in_valid = 1'b1;
      run_until(20, 200);
      drain_check();
      chk("stats_beat_cnt", beat_cnt, 16'h000F);
      $display("test stats done");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
